// File: rtl/idu_ir_rt_entry_ckpt.sv
// Rename-table entry for one architectural register, with branch checkpoint slots that snoop writebacks.
// Outputs are registered, except ready_bypass, which also reflects writebacks in the current cycle.
module idu_ir_rt_entry_ckpt #(
  parameter int PREG_W     = 6,
  parameter int WB_NUM     = 5,
  parameter int CKPT_NUM   = 4,
  parameter int CKPT_IDX_W = 2
) (
  input  logic                       clk,
  input  logic                       rst_clk,
  input  logic [PREG_W-1:0]          reset_mapped_preg,
  input  logic                       rtu_global_flush,
  input  logic [PREG_W-1:0]          recover_preg,
  input  logic                       y_idu_ir_stall_ctrl,
  input  logic                       map_update_vld,
  input  logic [PREG_W-1:0]          update_preg,
  input  logic [WB_NUM-1:0]          wb_vld,
  input  logic [WB_NUM*PREG_W-1:0]   wb_preg,
  input  logic                       ckpt_alloc_vld,
  input  logic [CKPT_IDX_W-1:0]      ckpt_alloc_idx,
  input  logic                       ckpt_restore_vld,
  input  logic [CKPT_IDX_W-1:0]      ckpt_restore_idx,
  output logic [PREG_W-1:0]          preg,
  output logic                       ready,
  output logic                       ready_bypass
);

  logic [PREG_W-1:0] r_preg;
  logic              r_ready;
  logic [PREG_W-1:0] r_ckpt_preg  [CKPT_NUM];
  logic              r_ckpt_ready [CKPT_NUM];

  logic              w_cur_wake;
  logic [CKPT_NUM-1:0] w_slot_wake;
  logic [PREG_W-1:0] w_nxt_preg;
  logic              w_nxt_ready;
  logic              w_alloc_acc;

  // Each comparator set matches one tracked preg against every writeback port.
  always_comb begin
    w_cur_wake  = 1'b0;
    w_slot_wake = '0;
    for (int i = 0; i < WB_NUM; i++) begin
      if (wb_vld[i] && wb_preg[i*PREG_W +: PREG_W] == r_preg)
        w_cur_wake = 1'b1;
      for (int k = 0; k < CKPT_NUM; k++) begin
        if (wb_vld[i] && wb_preg[i*PREG_W +: PREG_W] == r_ckpt_preg[k])
          w_slot_wake[k] = 1'b1;
      end
    end
  end

  // A freshly allocated preg cannot be in flight, so an update clears ready
  // without looking at writebacks.
  always_comb begin
    w_nxt_preg  = r_preg;
    w_nxt_ready = r_ready | w_cur_wake;
    if (rtu_global_flush) begin
      w_nxt_preg  = recover_preg;
      w_nxt_ready = 1'b1;
    end else if (ckpt_restore_vld) begin
      w_nxt_preg  = r_ckpt_preg[ckpt_restore_idx];
      w_nxt_ready = r_ckpt_ready[ckpt_restore_idx] | w_slot_wake[ckpt_restore_idx];
    end else if (!y_idu_ir_stall_ctrl && map_update_vld) begin
      w_nxt_preg  = update_preg;
      w_nxt_ready = 1'b0;
    end
  end

  assign w_alloc_acc = ckpt_alloc_vld & ~y_idu_ir_stall_ctrl & ~rtu_global_flush & ~ckpt_restore_vld;

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      r_preg  <= reset_mapped_preg;
      r_ready <= 1'b1;
      for (int k = 0; k < CKPT_NUM; k++) begin
        r_ckpt_preg[k]  <= reset_mapped_preg;
        r_ckpt_ready[k] <= 1'b1;
      end
    end else begin
      r_preg  <= w_nxt_preg;
      r_ready <= w_nxt_ready;
      for (int k = 0; k < CKPT_NUM; k++) begin
        if (rtu_global_flush) begin
          r_ckpt_preg[k]  <= recover_preg;
          r_ckpt_ready[k] <= 1'b1;
        end else if (w_alloc_acc && ckpt_alloc_idx == CKPT_IDX_W'(k)) begin
          // Snapshot the post-update state so a same-cycle rename is included.
          r_ckpt_preg[k]  <= w_nxt_preg;
          r_ckpt_ready[k] <= w_nxt_ready;
        end else begin
          r_ckpt_ready[k] <= r_ckpt_ready[k] | w_slot_wake[k];
        end
      end
    end
  end

  assign preg         = r_preg;
  assign ready        = r_ready;
  assign ready_bypass = r_ready | w_cur_wake;

endmodule

// File: tb/tb_idu_ir_rt_entry_ckpt.sv
// Directed bench for idu_ir_rt_entry_ckpt: linear steps with hand-computed expectations.
module tb_idu_ir_rt_entry_ckpt;

  localparam int PREG_W = 6;
  localparam int WB_NUM = 5;

  logic                     clk = 1'b0;
  logic                     rst_clk;
  logic [PREG_W-1:0]        reset_mapped_preg;
  logic                     rtu_global_flush;
  logic [PREG_W-1:0]        recover_preg;
  logic                     y_idu_ir_stall_ctrl;
  logic                     map_update_vld;
  logic [PREG_W-1:0]        update_preg;
  logic [WB_NUM-1:0]        wb_vld;
  logic [WB_NUM*PREG_W-1:0] wb_preg;
  logic                     ckpt_alloc_vld;
  logic [1:0]               ckpt_alloc_idx;
  logic                     ckpt_restore_vld;
  logic [1:0]               ckpt_restore_idx;
  logic [PREG_W-1:0]        preg;
  logic                     ready;
  logic                     ready_bypass;

  int total = 0;
  int bad   = 0;

  idu_ir_rt_entry_ckpt #(.PREG_W(6), .WB_NUM(5), .CKPT_NUM(4), .CKPT_IDX_W(2)) dut (
    .clk                 (clk),
    .rst_clk             (rst_clk),
    .reset_mapped_preg   (reset_mapped_preg),
    .rtu_global_flush    (rtu_global_flush),
    .recover_preg        (recover_preg),
    .y_idu_ir_stall_ctrl (y_idu_ir_stall_ctrl),
    .map_update_vld      (map_update_vld),
    .update_preg         (update_preg),
    .wb_vld              (wb_vld),
    .wb_preg             (wb_preg),
    .ckpt_alloc_vld      (ckpt_alloc_vld),
    .ckpt_alloc_idx      (ckpt_alloc_idx),
    .ckpt_restore_vld    (ckpt_restore_vld),
    .ckpt_restore_idx    (ckpt_restore_idx),
    .preg                (preg),
    .ready               (ready),
    .ready_bypass        (ready_bypass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] exp_preg, input logic exp_rdy);
    chk({tag, ".preg"}, {2'b00, preg}, exp_preg);
    chk({tag, ".ready"}, {7'd0, ready}, {7'd0, exp_rdy});
  endtask

  task automatic idle();
    rtu_global_flush    = 1'b0;
    recover_preg        = '0;
    y_idu_ir_stall_ctrl = 1'b0;
    map_update_vld      = 1'b0;
    update_preg         = '0;
    wb_vld              = '0;
    wb_preg             = '0;
    ckpt_alloc_vld      = 1'b0;
    ckpt_alloc_idx      = '0;
    ckpt_restore_vld    = 1'b0;
    ckpt_restore_idx    = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic upd(input logic [PREG_W-1:0] p);
    map_update_vld = 1'b1;
    update_preg    = p;
  endtask

  task automatic wb(input int port, input logic [PREG_W-1:0] p);
    wb_vld[port]                = 1'b1;
    wb_preg[port*PREG_W +: PREG_W] = p;
  endtask

  task automatic restore(input logic [1:0] idx);
    ckpt_restore_vld = 1'b1;
    ckpt_restore_idx = idx;
  endtask

  task automatic alloc(input logic [1:0] idx);
    ckpt_alloc_vld = 1'b1;
    ckpt_alloc_idx = idx;
  endtask

  initial begin
    idle();
    reset_mapped_preg = 6'd5;
    rst_clk = 1'b0;
    #12;
    chk_state("reset", 8'd5, 1'b1);
    chk("reset.bypass", {7'd0, ready_bypass}, 8'd1);
    rst_clk = 1'b1;
    @(posedge clk); #1;

    // Update, then writeback on port 3: bypass same cycle, ready next cycle.
    upd(6'd20);
    tick();
    chk_state("upd20", 8'd20, 1'b0);
    chk("upd20.bypass", {7'd0, ready_bypass}, 8'd0);
    wb(3, 6'd20);
    #1;
    chk("wb3.bypass", {7'd0, ready_bypass}, 8'd1);
    chk("wb3.ready_same", {7'd0, ready}, 8'd0);
    tick();
    chk_state("wb3.next", 8'd20, 1'b1);

    // Asynchronous reset mid-operation restores reset values immediately.
    #2;
    rst_clk = 1'b0;
    #1;
    chk_state("midrst", 8'd5, 1'b1);
    rst_clk = 1'b1;
    @(posedge clk); #1;

    // Stall blocks the update; dropping stall lets it apply.
    y_idu_ir_stall_ctrl = 1'b1;
    upd(6'd20);
    tick();
    chk_state("stall", 8'd5, 1'b1);
    upd(6'd20);
    tick();
    chk_state("unstall", 8'd20, 1'b0);

    // A writeback matching the newly allocated preg in the update cycle is ignored.
    upd(6'd44);
    wb(1, 6'd44);
    tick();
    chk_state("upd_wb_same", 8'd44, 1'b0);

    // Alloc slot 2 with update to 33; slot snoops writeback of 33 while entry moves on.
    upd(6'd33);
    alloc(2'd2);
    tick();
    chk_state("alloc2", 8'd33, 1'b0);
    upd(6'd40);
    tick();
    chk_state("upd40", 8'd40, 1'b0);
    wb(0, 6'd33);
    #1;
    chk("wb33.bypass", {7'd0, ready_bypass}, 8'd0);
    tick();
    chk_state("wb33.entry", 8'd40, 1'b0);
    restore(2'd2);
    tick();
    chk_state("restore2", 8'd33, 1'b1);

    // Slot 1 holds (12,0); restore with a same-cycle writeback of 12, stall and update discarded.
    upd(6'd12);
    alloc(2'd1);
    tick();
    upd(6'd50);
    tick();
    chk_state("upd50", 8'd50, 1'b0);
    restore(2'd1);
    wb(4, 6'd12);
    y_idu_ir_stall_ctrl = 1'b1;
    upd(6'd60);
    tick();
    chk_state("restore1_wb", 8'd12, 1'b1);

    // Alloc immediately followed by restore of the same slot.
    upd(6'd25);
    alloc(2'd2);
    tick();
    restore(2'd2);
    tick();
    chk_state("alloc_restore_b2b", 8'd25, 1'b0);

    // Global flush overrides restore and alloc, and resets every slot.
    rtu_global_flush = 1'b1;
    recover_preg     = 6'd7;
    restore(2'd1);
    alloc(2'd2);
    upd(6'd30);
    tick();
    chk_state("flush", 8'd7, 1'b1);
    upd(6'd9);
    tick();
    chk_state("upd9", 8'd9, 1'b0);
    restore(2'd2);
    tick();
    chk_state("flush.slot2", 8'd7, 1'b1);
    upd(6'd9);
    tick();
    restore(2'd1);
    tick();
    chk_state("flush.slot1", 8'd7, 1'b1);

    // Restore and alloc to the same slot: restore wins.
    upd(6'd15);
    alloc(2'd0);
    tick();
    upd(6'd16);
    tick();
    restore(2'd0);
    alloc(2'd0);
    upd(6'd17);
    tick();
    chk_state("restore_alloc0", 8'd15, 1'b0);
    upd(6'd18);
    tick();
    restore(2'd0);
    tick();
    chk_state("slot0_kept", 8'd15, 1'b0);

    // Alloc during a restore to another slot is dropped; slot 3 keeps flush contents.
    restore(2'd0);
    alloc(2'd3);
    tick();
    restore(2'd3);
    tick();
    chk_state("slot3_drop", 8'd7, 1'b1);

    // Alloc under stall is dropped; slot 1 keeps flush contents.
    upd(6'd22);
    tick();
    y_idu_ir_stall_ctrl = 1'b1;
    alloc(2'd1);
    tick();
    chk_state("stall_alloc.entry", 8'd22, 1'b0);
    restore(2'd1);
    tick();
    chk_state("slot1_drop", 8'd7, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idu_ir_rt_entry_ckpt.md
# idu_ir_rt_entry_ckpt

Parametrised rename-table entry for one architectural register in the IDU IR stage. It holds the current physical-register mapping and its ready bit, and wakes up on any of `WB_NUM` writeback ports. It adds `CKPT_NUM` branch checkpoint slots, each of which snoops writebacks, so a mispredict restores the mapping with an up-to-date ready bit. One instance exists per architectural register; rename control drives the shared allocate/restore indices to all instances.

## Interface
Parameters:
- PREG_W, 6, physical register index width
- WB_NUM, 5, number of writeback ports
- CKPT_NUM, 4, number of checkpoint slots
- CKPT_IDX_W, 2, checkpoint index width; must equal clog2(CKPT_NUM)

Ports:
- clk  in  1  clock
- rst_clk  in  1  asynchronous, active-low reset
- reset_mapped_preg  in  PREG_W  mapping loaded at reset; static
- rtu_global_flush  in  1  commit-side flush
- recover_preg  in  PREG_W  retired mapping loaded on global flush
- y_idu_ir_stall_ctrl  in  1  IR stall; blocks update and alloc
- map_update_vld  in  1  rename writes this arch reg
- update_preg  in  PREG_W  newly allocated preg
- wb_vld  in  WB_NUM  per-port writeback valid
- wb_preg  in  WB_NUM*PREG_W  per-port writeback preg; port i occupies bits [i*PREG_W +: PREG_W]
- ckpt_alloc_vld  in  1  take a snapshot into slot ckpt_alloc_idx
- ckpt_alloc_idx  in  CKPT_IDX_W  slot to write
- ckpt_restore_vld  in  1  branch mispredict; restore from slot ckpt_restore_idx
- ckpt_restore_idx  in  CKPT_IDX_W  slot to read
- preg  out  PREG_W  current mapping (registered)
- ready  out  1  current mapping's value is written back (registered)
- ready_bypass  out  1  ready, or a matching writeback in this cycle (combinational)

## Operation
- Wake function: wake(p) = OR over i of (wb_vld[i] & wb_preg[i] == p). Multiple matching ports are ORed.
- Next-state priority for preg/ready, highest first:
  - Reset: preg = reset_mapped_preg, ready = 1.
  - rtu_global_flush: preg = recover_preg, ready = 1.
  - ckpt_restore_vld: preg = ckpt_preg[r], ready = ckpt_ready[r] | wake(ckpt_preg[r]), where r = ckpt_restore_idx.
  - y_idu_ir_stall_ctrl: preg holds; ready = ready | wake(preg).
  - map_update_vld: preg = update_preg, ready = 0. A writeback matching update_preg in the same cycle is ignored, because a freshly allocated preg cannot be in flight.
  - Otherwise: preg holds; ready = ready | wake(preg).
- Checkpoint slot k, each cycle, highest priority first:
  - Reset: ckpt_preg = reset_mapped_preg, ckpt_ready = 1.
  - Global flush: ckpt_preg = recover_preg, ckpt_ready = 1.
  - Alloc accepted with ckpt_alloc_idx == k: the slot loads the entry's next-state preg/ready. The snapshot therefore includes an update in the same cycle.
  - Otherwise: ckpt_ready |= wake(ckpt_preg). ckpt_preg holds.
- An alloc is accepted only when ckpt_alloc_vld & ~stall & ~global flush & ~ckpt_restore_vld. Otherwise it is dropped with no slot change.
- Restore ignores stall and map_update_vld in the same cycle; both are discarded.
- Restore and alloc to the same slot in one cycle: restore wins; the slot keeps snooping.
- Slots carry no valid bit. Rename control guarantees that it restores only slots it has allocated. Restoring a never-allocated slot returns its reset or flush contents.
- ready_bypass = ready | wake(preg). Issue logic uses it for same-cycle wakeup.

## Timing
- preg, ready and all slots are registered. An update, restore or flush is visible on the next clock edge.
- A writeback in cycle N:
  - ready_bypass goes high in cycle N.
  - ready goes high in cycle N+1.
  - A slot holding that preg shows ckpt_ready = 1 from N+1.
- Restore latency is 1 cycle. A writeback in the restore cycle that matches the restored preg is not lost.
- Alloc then restore of the same slot: the earliest legal restore is the cycle after alloc.
- rst_clk is asynchronous. Asserting it mid-operation forces the reset values immediately; no partial state survives.
- Reset values: preg = reset_mapped_preg, ready = 1, ready_bypass = 1, all slots = (reset_mapped_preg, 1).

## Test plan
- Reset with reset_mapped_preg=6'd5 -> preg=5, ready=1, ready_bypass=1. Update to 6'd20 -> next cycle preg=20, ready=0. Then wb_vld[3]=1 with preg 20 -> ready_bypass=1 the same cycle, ready=1 next cycle.
- Update to 20 with stall=1 -> preg stays 5, ready unchanged. Drop stall -> update applies.
- Alloc slot 2 together with update to 33 -> slot2=(33,0). Update to 40. Writeback of 33 on port 0 -> slot2 ready becomes 1. Restore slot 2 -> preg=33, ready=1.
- Restore slot 1 holding (12,0) while wb port 4 carries 12 in the same cycle -> preg=12, ready=1 next cycle.
- Global flush together with restore and alloc, recover_preg=7 -> preg=7, ready=1, all slots=(7,1).
- Restore and alloc both targeting slot 0 -> restore applies; slot 0 unchanged. Alloc with stall=1 -> slot unchanged.
